thor2024_regfile_valid_ckpt: RTL and testbench

Parametrised register-valid and source-tag tracker for the Thor2024 out-of-order core. It sits between the rename/dispatch stage and the commit stage. It owns, for every architectural register, a valid bit and the tag of the queue entry that will produce it. It also keeps a bank of checkpoints so that a branch miss restores exact rename state in one cycle, instead of the approximate livetarget-based repair.

---
 rtl/thor2024_regfile_valid_ckpt_pkg.sv | 34 +++
 rtl/thor2024_regfile_valid_ckpt_if.sv | 34 +++
 rtl/thor2024_regfile_valid_ckpt_rfv_ckpt_bank.sv | 112 +++++++++++
 rtl/thor2024_regfile_valid_ckpt.sv | 96 +++++++++
 tb/tb_thor2024_regfile_valid_ckpt.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/thor2024_regfile_valid_ckpt_pkg.sv
// Shared types for the Thor2024 register-valid tracker: register specifier, checkpoint id and
// the rename-state snapshot, plus the tag-matched commit update used on live and checkpointed state.
package thor2024_regfile_valid_ckpt_pkg;

   localparam int P_AREGS = 64;
   localparam int P_TAGW  = 5;
   localparam int P_NDISP = 2;
   localparam int P_NCMT  = 2;
   localparam int P_NCKPT = 4;
   localparam int P_REGW  = $clog2(P_AREGS);
   localparam int P_CKW   = $clog2(P_NCKPT);

   typedef logic [P_REGW-1:0] regspec_t;
   typedef logic [P_CKW-1:0]  ckpt_id_t;
   typedef logic [P_TAGW-1:0] tag_t;

   typedef struct packed {
      logic [P_AREGS-1:0] valid;
      tag_t [P_AREGS-1:0] src;
   } rfv_ckpt_t;

   localparam rfv_ckpt_t RFV_RESET = '{valid: '1, src: '0};

   // A commit only marks a register valid if it is still waiting on exactly that producer.
   function automatic rfv_ckpt_t rfv_commit(input rfv_ckpt_t s, input logic v,
                                            input regspec_t tgt, input tag_t tag);
      rfv_ckpt_t r;
      r = s;
      if (v && (tgt != '0) && !s.valid[tgt] && (s.src[tgt] == tag))
         r.valid[tgt] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/thor2024_regfile_valid_ckpt_if.sv
// Dispatch, commit, miss/resolve and register-state bundle between rename/commit logic and the tracker.
interface thor2024_regfile_valid_ckpt_if;
   import thor2024_regfile_valid_ckpt_pkg::*;

   logic     [P_NDISP-1:0] disp_v;
   logic     [P_NDISP-1:0] disp_rfw;
   regspec_t [P_NDISP-1:0] disp_rt;
   tag_t     [P_NDISP-1:0] disp_tag;
   logic     [P_NDISP-1:0] disp_ckpt;
   logic     [P_NCMT-1:0]  cmt_v;
   regspec_t [P_NCMT-1:0]  cmt_tgt;
   tag_t     [P_NCMT-1:0]  cmt_tag;
   logic                   miss;
   ckpt_id_t               miss_ckpt;
   logic                   rsv_v;
   ckpt_id_t               rsv_ckpt;
   ckpt_id_t [P_NDISP-1:0] ckpt_id;
   logic                   ckpt_stall;
   logic     [P_AREGS-1:0] rf_v;
   tag_t     [P_AREGS-1:0] rf_source;

   modport master (
      output disp_v, disp_rfw, disp_rt, disp_tag, disp_ckpt,
      output cmt_v, cmt_tgt, cmt_tag, miss, miss_ckpt, rsv_v, rsv_ckpt,
      input  ckpt_id, ckpt_stall, rf_v, rf_source
   );

   modport slave (
      input  disp_v, disp_rfw, disp_rt, disp_tag, disp_ckpt,
      input  cmt_v, cmt_tgt, cmt_tag, miss, miss_ckpt, rsv_v, rsv_ckpt,
      output ckpt_id, ckpt_stall, rf_v, rf_source
   );

endinterface

// File: rtl/thor2024_regfile_valid_ckpt_rfv_ckpt_bank.sv
// Checkpoint bank: snapshots, free list and age matrix; grants and shortfall are combinational.
// In-use snapshots absorb tag-matched commits each cycle so a restore is exact.
module thor2024_rfv_ckpt_bank
   import thor2024_regfile_valid_ckpt_pkg::*;
#(
   parameter int NDISP = P_NDISP,
   parameter int NCMT  = P_NCMT,
   parameter int NCKPT = P_NCKPT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NDISP-1:0]     i_req,
   input  logic                 i_alloc_en,
   input  rfv_ckpt_t            i_snap [NDISP],
   input  logic [NCMT-1:0]      i_cmt_v,
   input  regspec_t [NCMT-1:0]  i_cmt_tgt,
   input  tag_t [NCMT-1:0]      i_cmt_tag,
   input  logic                 i_miss,
   input  ckpt_id_t             i_miss_ckpt,
   input  logic                 i_rsv_v,
   input  ckpt_id_t             i_rsv_ckpt,
   output ckpt_id_t [NDISP-1:0] o_ckpt_id,
   output logic                 o_short,
   output rfv_ckpt_t            o_restore
);

   logic [NCKPT-1:0]            r_inuse;
   logic [NCKPT-1:0]            w_inuse_nxt;
   logic [NCKPT-1:0][NCKPT-1:0] r_age;       // r_age[i][j]: i was allocated after j
   logic [NCKPT-1:0][NCKPT-1:0] w_age_nxt;
   logic [NDISP-1:0][NCKPT-1:0] w_grant;
   rfv_ckpt_t                   r_ckpt     [NCKPT];
   rfv_ckpt_t                   w_ckpt_nxt [NCKPT];

   always_comb begin : grant
      logic [NCKPT-1:0] v_free;
      logic             v_found;
      v_free    = ~r_inuse;
      w_grant   = '0;
      o_ckpt_id = '0;
      o_short   = 1'b0;
      for (int k = 0; k < NDISP; k++) begin
         v_found = 1'b0;
         if (i_req[k]) begin
            for (int i = 0; i < NCKPT; i++) begin
               if (!v_found && v_free[i]) begin
                  v_found       = 1'b1;
                  v_free[i]     = 1'b0;
                  w_grant[k][i] = 1'b1;
                  o_ckpt_id[k]  = ckpt_id_t'(i);
               end
            end
            if (!v_found)
               o_short = 1'b1;
         end
      end
   end

   always_comb begin : next_state
      logic [NCKPT-1:0] v_grp;
      w_inuse_nxt = r_inuse;
      w_age_nxt   = r_age;
      v_grp       = '0;
      for (int i = 0; i < NCKPT; i++) begin
         w_ckpt_nxt[i] = r_ckpt[i];
         if (r_inuse[i]) begin
            for (int c = 0; c < NCMT; c++)
               w_ckpt_nxt[i] = rfv_commit(w_ckpt_nxt[i], i_cmt_v[c], i_cmt_tgt[c], i_cmt_tag[c]);
         end
      end
      if (i_rsv_v)
         w_inuse_nxt[i_rsv_ckpt] = 1'b0;
      if (i_miss) begin
         w_inuse_nxt[i_miss_ckpt] = 1'b0;
         for (int i = 0; i < NCKPT; i++)
            if (r_age[i][i_miss_ckpt])
               w_inuse_nxt[i] = 1'b0;
      end else if (i_alloc_en) begin
         // Within a group, older slots' checkpoints count as older than this slot's.
         for (int k = 0; k < NDISP; k++) begin
            for (int i = 0; i < NCKPT; i++) begin
               if (w_grant[k][i]) begin
                  w_inuse_nxt[i] = 1'b1;
                  w_ckpt_nxt[i]  = i_snap[k];
                  for (int j = 0; j < NCKPT; j++)
                     w_age_nxt[j][i] = 1'b0;
                  w_age_nxt[i] = r_inuse | v_grp;
               end
            end
            v_grp = v_grp | w_grant[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_inuse <= '0;
         r_age   <= '0;
      end else begin
         r_inuse <= w_inuse_nxt;
         r_age   <= w_age_nxt;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NCKPT; i++)
         r_ckpt[i] <= w_ckpt_nxt[i];
   end

   assign o_restore = r_ckpt[i_miss_ckpt];

endmodule

// File: rtl/thor2024_regfile_valid_ckpt.sv
// Register valid/source tracker with single-cycle exact checkpoint restore; state updates show one cycle later.
// ckpt_stall is combinational and freezes the dispatch group; THOR2024_RFV_BYPASS_EN adds same-cycle commits on rf_v.
module thor2024_regfile_valid_ckpt
   import thor2024_regfile_valid_ckpt_pkg::*;
#(
   parameter int AREGS = P_AREGS,
   parameter int TAGW  = P_TAGW,
   parameter int NDISP = P_NDISP,
   parameter int NCMT  = P_NCMT,
   parameter int NCKPT = P_NCKPT
) (
   input  logic                         clk,
   input  logic                         rst,
   thor2024_regfile_valid_ckpt_if.slave io_rfv
);

   rfv_ckpt_t          r_live;
   rfv_ckpt_t          w_base;
   rfv_ckpt_t          w_restore;
   rfv_ckpt_t          w_restore_cmt;
   rfv_ckpt_t          w_next;
   rfv_ckpt_t          w_snap [NDISP];
   logic [NDISP-1:0]   w_req;
   logic               w_short;
   logic               w_stall;
   logic [AREGS-1:0]   w_rf_v;

   assign w_req   = io_rfv.disp_v & io_rfv.disp_ckpt;
   assign w_stall = io_rfv.miss | w_short;

   always_comb begin
      rfv_ckpt_t v_s;
      w_base        = r_live;
      w_restore_cmt = w_restore;
      for (int c = 0; c < NCMT; c++) begin
         w_base        = rfv_commit(w_base, io_rfv.cmt_v[c], io_rfv.cmt_tgt[c], io_rfv.cmt_tag[c]);
         w_restore_cmt = rfv_commit(w_restore_cmt, io_rfv.cmt_v[c], io_rfv.cmt_tgt[c],
                                    io_rfv.cmt_tag[c]);
      end
      // Dispatch lands on top of this cycle's commits: the new producer is younger.
      v_s = w_base;
      for (int k = 0; k < NDISP; k++) begin
         if (io_rfv.disp_v[k] && io_rfv.disp_rfw[k] && (io_rfv.disp_rt[k] != '0)) begin
            v_s.valid[io_rfv.disp_rt[k]] = 1'b0;
            v_s.src[io_rfv.disp_rt[k]]   = io_rfv.disp_tag[k];
         end
         w_snap[k] = v_s;
      end
      if (io_rfv.miss)
         w_next = w_restore_cmt;
      else if (!w_stall)
         w_next = v_s;
      else
         w_next = w_base;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_live <= RFV_RESET;
      else
         r_live <= w_next;
   end

   thor2024_rfv_ckpt_bank #(
      .NDISP (NDISP),
      .NCMT  (NCMT),
      .NCKPT (NCKPT)
   ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .i_req       (w_req),
      .i_alloc_en  (!w_stall),
      .i_snap      (w_snap),
      .i_cmt_v     (io_rfv.cmt_v),
      .i_cmt_tgt   (io_rfv.cmt_tgt),
      .i_cmt_tag   (io_rfv.cmt_tag),
      .i_miss      (io_rfv.miss),
      .i_miss_ckpt (io_rfv.miss_ckpt),
      .i_rsv_v     (io_rfv.rsv_v),
      .i_rsv_ckpt  (io_rfv.rsv_ckpt),
      .o_ckpt_id   (io_rfv.ckpt_id),
      .o_short     (w_short),
      .o_restore   (w_restore)
   );

`ifdef THOR2024_RFV_BYPASS_EN
   assign w_rf_v = w_base.valid;
`else
   assign w_rf_v = r_live.valid;
`endif

   assign io_rfv.ckpt_stall = w_stall;
   assign io_rfv.rf_v       = {w_rf_v[AREGS-1:1], 1'b1};
   assign io_rfv.rf_source  = {r_live.src[AREGS-1:1], {TAGW{1'b0}}};

endmodule

// File: tb/tb_thor2024_regfile_valid_ckpt.sv
// Directed bench for the register-valid tracker: dispatch/commit ordering, checkpoint restore, stall and reset.
`timescale 1ns/1ps
module tb_thor2024_regfile_valid_ckpt;
   import thor2024_regfile_valid_ckpt_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   thor2024_regfile_valid_ckpt_if u_if ();

   thor2024_regfile_valid_ckpt u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_rfv (u_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic idle();
      u_if.disp_v    = '0;
      u_if.disp_rfw  = '0;
      u_if.disp_rt   = '0;
      u_if.disp_tag  = '0;
      u_if.disp_ckpt = '0;
      u_if.cmt_v     = '0;
      u_if.cmt_tgt   = '0;
      u_if.cmt_tag   = '0;
      u_if.miss      = 1'b0;
      u_if.miss_ckpt = '0;
      u_if.rsv_v     = 1'b0;
      u_if.rsv_ckpt  = '0;
   endtask

   task automatic disp(input int s, input logic rfw, input int rt, input int tag, input logic ck);
      u_if.disp_v[s]    = 1'b1;
      u_if.disp_rfw[s]  = rfw;
      u_if.disp_rt[s]   = regspec_t'(rt);
      u_if.disp_tag[s]  = tag_t'(tag);
      u_if.disp_ckpt[s] = ck;
   endtask

   task automatic cmt(input int p, input int tgt, input int tag);
      u_if.cmt_v[p]   = 1'b1;
      u_if.cmt_tgt[p] = regspec_t'(tgt);
      u_if.cmt_tag[p] = tag_t'(tag);
   endtask

   task automatic do_miss(input int c);
      u_if.miss      = 1'b1;
      u_if.miss_ckpt = ckpt_id_t'(c);
   endtask

   // Advance one clock, then clear all inputs for the next cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      idle();
      #2 rst = 1'b0;
      #1;
      check("rst_rfv",   u_if.rf_v, '1);
      check("rst_src",   64'(|u_if.rf_source), 0);
      check("rst_stall", 64'(u_if.ckpt_stall), 0);
      check("rst_id",    64'(u_if.ckpt_id), 0);
      @(negedge clk) rst = 1'b1;
      tick();

      // Dispatch then commit of the same producer.
      disp(0, 1, 5, 3, 0);
      tick();
      cmt(0, 5, 3);
      check("r5_pend_v", 64'(u_if.rf_v[5]), 0);
      check("r5_src",    64'(u_if.rf_source[5]), 3);
      tick();
      check("r5_done_v", 64'(u_if.rf_v[5]), 1);

      // Same target twice in one group: slot 1 wins; r0 never changes.
      disp(0, 1, 7, 2, 0);
      disp(1, 1, 7, 4, 0);
      tick();
      check("r7_v0",  64'(u_if.rf_v[7]), 0);
      check("r7_src", 64'(u_if.rf_source[7]), 4);
      cmt(0, 7, 2);
      disp(0, 1, 0, 5, 0);
      tick();
      check("r7_stale_cmt", 64'(u_if.rf_v[7]), 0);
      check("r0_v",   64'(u_if.rf_v[0]), 1);
      check("r0_src", 64'(u_if.rf_source[0]), 0);
      cmt(1, 7, 4);
      tick();
      check("r7_done_v", 64'(u_if.rf_v[7]), 1);

      // Branch takes checkpoint 0, younger r9 is squashed by the miss.
      disp(0, 0, 0, 0, 1);
      #1;
      check("br_id0",    64'(u_if.ckpt_id[0]), 0);
      check("br_stall0", 64'(u_if.ckpt_stall), 0);
      tick();
      disp(0, 1, 9, 6, 0);
      tick();
      check("r9_v0", 64'(u_if.rf_v[9]), 0);
      do_miss(0);
      disp(0, 1, 11, 7, 0);
      #1;
      check("miss_stall", 64'(u_if.ckpt_stall), 1);
      tick();
      check("r9_restored_v",   64'(u_if.rf_v[9]), 1);
      check("r9_restored_src", 64'(u_if.rf_source[9]), 0);
      check("r11_ignored",     64'(u_if.rf_v[11]), 1);
      check("r5_kept_src",     64'(u_if.rf_source[5]), 3);

      // Commit after snapshot reaches the checkpoint; link register is in the snapshot.
      disp(0, 1, 3, 1, 0);
      disp(1, 1, 12, 8, 1);
      #1;
      check("ck0_free_id", 64'(u_if.ckpt_id[1]), 0);
      tick();
      check("r12_v0", 64'(u_if.rf_v[12]), 0);
      cmt(0, 3, 1);
      tick();
      check("r3_done_v", 64'(u_if.rf_v[3]), 1);
      disp(0, 1, 3, 9, 0);
      tick();
      check("r3_young_src", 64'(u_if.rf_source[3]), 9);
      do_miss(0);
      tick();
      check("r3_restore_v",   64'(u_if.rf_v[3]), 1);
      check("r3_restore_src", 64'(u_if.rf_source[3]), 1);
      check("r12_link_v",     64'(u_if.rf_v[12]), 0);
      check("r12_link_src",   64'(u_if.rf_source[12]), 8);

      // Exhaust four checkpoints, stall the fifth, resolve, then grant.
      disp(0, 0, 0, 0, 1);
      disp(1, 0, 0, 0, 1);
      #1;
      check("a_id0", 64'(u_if.ckpt_id[0]), 0);
      check("a_id1", 64'(u_if.ckpt_id[1]), 1);
      tick();
      disp(0, 0, 0, 0, 1);
      disp(1, 0, 0, 0, 1);
      #1;
      check("b_id1",    64'(u_if.ckpt_id[1]), 3);
      check("b_stall0", 64'(u_if.ckpt_stall), 0);
      tick();
      disp(0, 1, 20, 10, 1);
      #1;
      check("c_stall", 64'(u_if.ckpt_stall), 1);
      tick();
      check("c_no_change", 64'(u_if.rf_v[20]), 1);
      disp(0, 1, 20, 10, 1);
      u_if.rsv_v    = 1'b1;
      u_if.rsv_ckpt = ckpt_id_t'(2);
      #1;
      check("d_stall", 64'(u_if.ckpt_stall), 1);
      tick();
      disp(0, 1, 20, 10, 1);
      #1;
      check("e_stall0", 64'(u_if.ckpt_stall), 0);
      check("e_id0",    64'(u_if.ckpt_id[0]), 2);
      tick();
      check("r20_v0", 64'(u_if.rf_v[20]), 0);

      // Miss on checkpoint 1 frees 1 and everything younger (3 and the new 2).
      do_miss(1);
      tick();
      check("r20_squash_v", 64'(u_if.rf_v[20]), 1);
      disp(0, 0, 0, 0, 1);
      disp(1, 0, 0, 0, 1);
      #1;
      check("age_id0",    64'(u_if.ckpt_id[0]), 1);
      check("age_id1",    64'(u_if.ckpt_id[1]), 2);
      check("age_stall0", 64'(u_if.ckpt_stall), 0);
      tick();
      disp(0, 0, 0, 0, 1);
      disp(1, 0, 0, 0, 1);
      #1;
      check("age_stall1", 64'(u_if.ckpt_stall), 1);
      tick();

      // Dispatch beats a same-cycle commit on the same register.
      disp(0, 1, 40, 12, 0);
      tick();
      disp(0, 1, 40, 13, 0);
      cmt(0, 40, 12);
      tick();
      check("r40_v",   64'(u_if.rf_v[40]), 0);
      check("r40_src", 64'(u_if.rf_source[40]), 13);

      // Reset mid-operation with checkpoints in use.
      disp(0, 1, 30, 11, 0);
      tick();
      check("r30_v0", 64'(u_if.rf_v[30]), 0);
      #2 rst = 1'b0;
      disp(0, 0, 0, 0, 1);
      disp(1, 0, 0, 0, 1);
      #1;
      check("mid_rst_rfv",   u_if.rf_v, '1);
      check("mid_rst_stall", 64'(u_if.ckpt_stall), 0);
      check("mid_rst_id1",   64'(u_if.ckpt_id[1]), 1);
      @(negedge clk) rst = 1'b1;
      idle();
      tick();

      // Commit visibility in the commit cycle depends on the bypass build.
      disp(0, 1, 5, 2, 0);
      tick();
      cmt(0, 5, 2);
      #1;
`ifdef THOR2024_RFV_BYPASS_EN
      check("byp_same_cycle", 64'(u_if.rf_v[5]), 1);
`else
      check("byp_same_cycle", 64'(u_if.rf_v[5]), 0);
`endif
      tick();
      check("byp_next_cycle", 64'(u_if.rf_v[5]), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
